// File: rtl/udc_bus_collector_pkg.sv
// Shared constants and helpers for the per-module DC-link voltage bus.
// The PWM-side unpacker uses mod_msb() so both ends agree on bus layout.
package udc_bus_collector_pkg;

    localparam int unsigned N_MOD = 24;
    localparam int unsigned W     = 16;
    localparam int unsigned BUS_W = N_MOD * W;
    localparam int unsigned ACC_W = 21;
    localparam int unsigned CNT_W = 4;

    localparam logic [4:0] IDX_MIN = 5'd1;
    localparam logic [4:0] IDX_MAX = 5'd24;

    localparam int unsigned STALE_LIM_MIN = 1;
    localparam int unsigned STALE_LIM_MAX = 15;

    typedef enum logic [1:0] {
        StIdle,
        StSum,
        StDone
    } sum_state_e;

    // Module 1 sits in the top word of the bus.
    function automatic logic [8:0] mod_msb(input logic [4:0] k);
        return 9'(BUS_W - 1 - W * (32'(k) - 1));
    endfunction

endpackage

// File: rtl/udc_sum_seq.sv
// Sequential saturated sum of the published snapshot, one module word per cycle.
// A new sync restarts the walk and silently drops any sum in flight.
module udc_sum_seq
    import udc_bus_collector_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sync_i,
    input  logic [BUS_W-1:0] bus_i,
    output logic [W-1:0]     phase_udc_o,
    output logic             sum_valid_o
);

    sum_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       ptr_q, ptr_d;
    logic [W-1:0]     phase_q, phase_d;

    logic [W-1:0]     word;
    logic [ACC_W-1:0] acc_next;

    assign word     = bus_i[mod_msb(ptr_q) -: W];
    assign acc_next = acc_q + ACC_W'(word);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ptr_q   <= IDX_MIN;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ptr_d   = ptr_q;
        phase_d = phase_q;
        if (sync_i) begin
            state_d = StSum;
            acc_d   = '0;
            ptr_d   = IDX_MIN;
        end else begin
            case (state_q)
                StSum: begin
                    acc_d = acc_next;
                    if (ptr_q == IDX_MAX) begin
                        // Result is latched on the last add so it lines up with the DONE pulse.
                        state_d = StDone;
                        phase_d = (acc_next > ACC_W'(16'hFFFF)) ? '1 : acc_next[W-1:0];
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sum_valid_o = (state_q == StDone);
        phase_udc_o = phase_q;
    end

endmodule

// File: rtl/udc_bus_collector.sv
// Collects per-module Udc reports into shadow registers and publishes a coherent
// 384-bit snapshot on each carrier sync, with staleness tracking and phase sum.
module udc_bus_collector
    import udc_bus_collector_pkg::*;
#(
    parameter int unsigned STALE_LIM = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_udc_valid,
    input  logic [4:0]       i_udc_idx,
    input  logic [W-1:0]     i_udc_data,
    input  logic             i_Syn,
    output logic [BUS_W-1:0] o_LinkUdc_BUS,
    output logic [W-1:0]     o_Phase_Udc,
    output logic             o_sum_valid,
    output logic [N_MOD-1:0] o_stale,
    output logic             o_idx_err
);

    localparam int unsigned StaleLimC = (STALE_LIM < STALE_LIM_MIN) ? STALE_LIM_MIN :
                                        (STALE_LIM > STALE_LIM_MAX) ? STALE_LIM_MAX : STALE_LIM;
    localparam logic [CNT_W-1:0] StaleLim = CNT_W'(StaleLimC);

    logic             syn_q;
    logic [W-1:0]     shadow_q [N_MOD];
    logic [W-1:0]     shadow_d [N_MOD];
    logic [CNT_W-1:0] cnt_q    [N_MOD];
    logic [CNT_W-1:0] cnt_d    [N_MOD];
    logic [N_MOD-1:0] stale_q, stale_d;
    logic [BUS_W-1:0] bus_q, bus_d;
    logic             idx_err_q, idx_err_d;

    logic in_range, wr_ok, syn_edge;

    always_comb begin
        in_range  = (i_udc_idx >= IDX_MIN) && (i_udc_idx <= IDX_MAX);
        wr_ok     = i_udc_valid && in_range;
        idx_err_d = i_udc_valid && !in_range;
        syn_edge  = i_Syn && !syn_q;
    end

    // A write coinciding with a sync wins over the stale increment, and the
    // publish below still sees the pre-write shadow value.
    always_comb begin
        for (int k = 0; k < N_MOD; k++) begin
            shadow_d[k] = shadow_q[k];
            cnt_d[k]    = cnt_q[k];
            if (wr_ok && (i_udc_idx == 5'(k + 1))) begin
                shadow_d[k] = i_udc_data;
                cnt_d[k]    = '0;
            end else if (syn_edge && (cnt_q[k] < StaleLim)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
            stale_d[k] = (cnt_d[k] >= StaleLim);
        end
    end

    always_comb begin
        bus_d = bus_q;
        if (syn_edge) begin
            for (int k = 0; k < N_MOD; k++) begin
                bus_d[mod_msb(5'(k + 1)) -: W] = shadow_q[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            syn_q     <= 1'b0;
            stale_q   <= '1;
            bus_q     <= '0;
            idx_err_q <= 1'b0;
            for (int k = 0; k < N_MOD; k++) begin
                shadow_q[k] <= '0;
                cnt_q[k]    <= StaleLim;
            end
        end else begin
            syn_q     <= i_Syn;
            stale_q   <= stale_d;
            bus_q     <= bus_d;
            idx_err_q <= idx_err_d;
            for (int k = 0; k < N_MOD; k++) begin
                shadow_q[k] <= shadow_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
        end
    end

    assign o_LinkUdc_BUS = bus_q;
    assign o_stale       = stale_q;
    assign o_idx_err     = idx_err_q;

    udc_sum_seq u_sum_seq (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .sync_i      (syn_edge),
        .bus_i       (bus_q),
        .phase_udc_o (o_Phase_Udc),
        .sum_valid_o (o_sum_valid)
    );

endmodule

// File: tb/tb_udc_bus_collector.sv
// Directed plus randomized bench for udc_bus_collector against a report/sync
// level model: shadow words, published words and syncs-since-last-report.
module tb_udc_bus_collector;

    localparam int LIM = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [4:0]   idx = '0;
    logic [15:0]  data = '0;
    logic         syn = 1'b0;
    logic [383:0] bus;
    logic [15:0]  phase;
    logic         sum_valid;
    logic [23:0]  stale;
    logic         idx_err;

    always #5 clk = ~clk;

    udc_bus_collector #(.STALE_LIM(LIM)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_udc_valid   (valid),
        .i_udc_idx     (idx),
        .i_udc_data    (data),
        .i_Syn         (syn),
        .o_LinkUdc_BUS (bus),
        .o_Phase_Udc   (phase),
        .o_sum_valid   (sum_valid),
        .o_stale       (stale),
        .o_idx_err     (idx_err)
    );

    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] shadow_m [1:24];
    logic [15:0] pub_m    [1:24];
    int          since    [1:24];
    int          tick_n = 0;
    int          sync_tick = -1000;
    logic        syn_prev = 1'b0;
    logic [15:0] exp_phase = '0;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 1; m <= 24; m++) begin
            shadow_m[m] = '0;
            pub_m[m]    = '0;
            since[m]    = LIM;
        end
        sync_tick = -1000;
        syn_prev  = 1'b0;
        exp_phase = '0;
    endtask

    task automatic check_all(input logic exp_err, input logic exp_sv);
        logic [383:0] eb;
        logic [23:0]  es;
        for (int m = 1; m <= 24; m++) begin
            eb[383 - 16 * (m - 1) -: 16] = pub_m[m];
            es[m - 1] = (since[m] >= LIM);
        end
        chk("bus", bus, eb);
        chk("stale", 384'(stale), 384'(es));
        chk("sum_valid", 384'(sum_valid), 384'(exp_sv));
        chk("phase", 384'(phase), 384'(exp_phase));
        chk("idx_err", 384'(idx_err), 384'(exp_err));
    endtask

    task automatic tick(input logic v, input logic [4:0] i, input logic [15:0] d, input logic s);
        logic sedge, wr, sv;
        int   total;
        valid = v;
        idx   = i;
        data  = d;
        syn   = s;
        @(posedge clk);
        sedge    = s && !syn_prev;
        syn_prev = s;
        wr       = v && (i >= 1) && (i <= 24);
        if (sedge) begin
            for (int m = 1; m <= 24; m++) begin
                pub_m[m] = shadow_m[m];
                if (!(wr && (int'(i) == m))) since[m] = since[m] + 1;
            end
            sync_tick = tick_n;
        end
        if (wr) begin
            shadow_m[i] = d;
            since[i]    = 0;
        end
        sv = (tick_n == sync_tick + 24);
        if (sv) begin
            total = 0;
            for (int m = 1; m <= 24; m++) total += int'(pub_m[m]);
            exp_phase = (total > 65535) ? 16'hFFFF : 16'(total);
        end
        tick_n++;
        #1;
        check_all(v && !((i >= 1) && (i <= 24)), sv);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick(1'b0, 5'd0, 16'd0, 1'b0);
    endtask

    task automatic sync_pulse();
        tick(1'b0, 5'd0, 16'd0, 1'b1);
    endtask

    initial begin
        int pulses;
        model_reset();
        #23;
        check_all(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty snapshot; a level-high hold must yield a single event
        idle(3);
        tick(1'b0, 5'd0, 16'd0, 1'b1);
        tick(1'b0, 5'd0, 16'd0, 1'b1);
        tick(1'b0, 5'd0, 16'd0, 1'b1);
        idle(30);

        // Module k = 1000 + k
        for (int k = 1; k <= 24; k++) tick(1'b1, 5'(k), 16'(1000 + k), 1'b0);
        sync_pulse();
        idle(30);
        chk("mod1_1001", 384'(bus[383:368]), 384'(16'd1001));
        chk("mod24_1024", 384'(bus[15:0]), 384'(16'd1024));
        chk("phase_24300", 384'(phase), 384'(16'd24300));
        chk("stale_none", 384'(stale), 384'(24'h0));

        // Saturation
        for (int k = 1; k <= 24; k++) tick(1'b1, 5'(k), 16'h1000, 1'b0);
        sync_pulse();
        idle(30);
        chk("phase_sat", 384'(phase), 384'(16'hFFFF));

        // Write and sync in the same cycle
        tick(1'b1, 5'd5, 16'd777, 1'b1);
        idle(3);
        chk("mod5_old", 384'(bus[319:304]), 384'(16'h1000));
        chk("mod5_stale_clr", 384'(stale[4]), 384'(1'b0));
        idle(26);
        sync_pulse();
        idle(2);
        chk("mod5_new", 384'(bus[319:304]), 384'(16'd777));

        // Out-of-range indices
        tick(1'b1, 5'd0, 16'hDEAD, 1'b0);
        idle(1);
        tick(1'b1, 5'd25, 16'hBEEF, 1'b0);
        idle(1);
        sync_pulse();
        idle(30);

        // Module 7 goes stale after four unreported syncs
        tick(1'b1, 5'd7, 16'd4242, 1'b0);
        for (int r = 1; r <= 4; r++) begin
            for (int k = 1; k <= 24; k++) if (k != 7) tick(1'b1, 5'(k), 16'(r * 100 + k), 1'b0);
            sync_pulse();
            if (r == 3) chk("mod7_fresh", 384'(stale[6]), 384'(1'b0));
            if (r == 4) chk("mod7_stale", 384'(stale[6]), 384'(1'b1));
            idle(3);
        end
        idle(30);

        // Second sync 10 cycles into SUM: one pulse only
        sync_pulse();
        idle(10);
        sync_pulse();
        pulses = 0;
        for (int c = 0; c < 35; c++) begin
            tick(1'b0, 5'd0, 16'd0, 1'b0);
            if (sum_valid) pulses++;
        end
        chk("one_pulse", 384'(pulses), 384'(1));

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            tick(1'($urandom_range(0, 1)), 5'($urandom_range(0, 27)), 16'($urandom),
                 1'($urandom_range(0, 14) == 0));
        end

        // Asynchronous reset in the middle of a sum
        idle(2);
        sync_pulse();
        idle(8);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        for (int k = 1; k <= 24; k++) tick(1'b1, 5'(k), 16'(k * 7), 1'b0);
        sync_pulse();
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
